shift_regs_ctrl: RTL and testbench
==================================

# shift_regs_ctrl

Scheduler that owns the three shift-register implementations (flip-flop, SRL/distributed RAM, block RAM) and shares them with a single serial producer and consumer. Exactly one backend is active at a time, chosen by a runtime select. The enables and data inputs of unselected backends are held at 0 to minimise switching power. On a reconfiguration, in-flight data is drained from the old backend before the new one is enabled, so no bit is lost or duplicated.

## Interface
- DEPTH, 64, shift length of every backend in stages (≥2); counters are $clog2(DEPTH+1) bits wide
- clk  in  1  single clock for the controller and all backends
- reset_n  in  1  asynchronous, active-low reset
- cfg_sel  in  2  requested backend: 0 = flops, 1 = SRL, 2 = BRAM, 3 = off
- cfg_load  in  1  single-cycle strobe that applies cfg_sel
- in_valid  in  1  producer bit valid
- in_data  in  1  producer bit
- in_ready  out  1  controller accepts in_data this cycle
- out_valid  out  1  single-cycle pulse: out_data is a real producer bit
- out_data  out  1  emerging bit; there is no backpressure
- enable_shift_flops / enable_shift_ram / enable_shift_bram  out  1 each  backend shift enables
- shift_flops_din / shift_ram_din / shift_bram_din  out  1 each  backend data inputs
- shift_flops_dout / shift_ram_dout / shift_bram_dout  in  1 each  backend outputs; the value sampled in a shift cycle is the bit exiting at that edge
- cur_sel  out  2  backend currently driven
- busy  out  1  high in DRAIN or SWITCH

## Operation
- **States:** IDLE, RUN, DRAIN, SWITCH.
- **Reset:**
  - State goes to IDLE.
  - cur_sel = 3, pend_sel = 3, age = 0, real = 0.
  - All outputs are 0.
- **age:** shifts since the current backend was selected, saturating at DEPTH.
- **real:** producer bits inserted and not yet exited (0..DEPTH).
- **Shift cycle:** the enable of cur_sel is high for that cycle, and age is incremented (saturating).
- **Real-exit condition:** the exiting bit is real iff age == DEPTH and real > 0 before the shift. In that case the next edge sets out_valid = 1 and out_data = the sampled dout of cur_sel, and real is decremented.
- **IDLE:** in_ready = 0, all enables 0. A cfg_load with sel ≠ 3 goes to SWITCH.
- **RUN:**
  - in_ready = 1.
  - in_valid && in_ready causes a shift with din = in_data, and real is incremented.
  - The simultaneous exit/decrement nets to a hold.
  - With no in_valid there is no shift and the pipe holds; there are no bubbles.
- **cfg_load in RUN or IDLE:**
  - pend_sel <= cfg_sel.
  - sel == cur_sel: ignored.
  - real > 0: go to DRAIN.
  - real == 0: go to SWITCH.
  - A handshake in the same cycle as cfg_load still completes.
- **DRAIN:**
  - in_ready = 0.
  - Shift every cycle with din = 0.
  - When real reaches 0, go to SWITCH.
  - A further cfg_load overwrites pend_sel (last wins).
- **SWITCH:** lasts one cycle with all enables 0. Then cur_sel <= pend_sel, age = 0, real = 0, and the next state is IDLE if pend_sel == 3, else RUN. A cfg_load in SWITCH overwrites pend_sel before it is applied.
- **Unselected backends:** enable and din are constant 0 at all times.
- **Mid-operation reset_n:** all state clears immediately. Stale backend contents are never reported, because age restarts at 0.

## Timing
- Enables and dins are driven combinationally from state, cur_sel and the handshake. out_valid and out_data are registered.
- **Latency:** the k-th accepted bit appears on out_data 1 cycle after the (k+DEPTH)-th shift edge.
- **Drain length:** DRAIN lasts exactly (DEPTH − age) + real cycles, clamped at real when age == DEPTH.
- **Reconfiguration gap:** SWITCH is one cycle; in_ready returns the cycle after SWITCH.

## Test plan
- **Steady stream:** DEPTH=16, sel=0, stream pattern 1..20 contiguously. Expect exactly 4 out_valid pulses carrying bits 1..4. The first pulse occurs the cycle after the 17th accept. enable_shift_ram and enable_shift_bram stay 0 throughout.
- **Stalls:** as the steady-stream case, but with in_valid deasserted every third cycle. The output sequence is identical and there are no extra out_valid pulses.
- **Switch after fill:** DEPTH=16, sel=1, feed 20 bits, then cfg_load sel=2.
  - DRAIN lasts 16 cycles.
  - out_valid emits bits 5..20 in order.
  - SWITCH lasts 1 cycle, then cur_sel = 2 and in_ready = 1.
- **Switch before fill:** feed 5 bits on sel=0, then cfg_load sel=2.
  - DRAIN lasts 16 cycles.
  - Exactly 5 out_valid pulses, from the last 5 drain shifts.
  - Zero pulses for stale data.
- **Load to off / same select:** cfg_load sel=3 with real = 0 goes SWITCH → IDLE, all enables 0, busy high for 1 cycle. cfg_load with sel == cur_sel causes no state change.
- **Reset mid-DRAIN:** assert reset_n low during DRAIN. All outputs go to 0 immediately and cur_sel = 3. After selecting a backend again, the first out_valid occurs only after DEPTH+1 accepts.

Source files
------------

// File: rtl/shift_regs_ctrl_if.sv
// Serial producer/consumer link of the shift-register scheduler.
// The producer side uses a valid/ready handshake; the consumer side has no backpressure.
interface shift_regs_ctrl_if;
  logic in_valid;
  logic in_data;
  logic in_ready;
  logic out_valid;
  logic out_data;

  modport slave (
    input  in_valid,
    input  in_data,
    output in_ready,
    output out_valid,
    output out_data
  );

  modport master (
    output in_valid,
    output in_data,
    input  in_ready,
    input  out_valid,
    input  out_data
  );
endinterface

// File: rtl/shift_regs_ctrl.sv
// Shares one of three shift-register backends with a serial stream and drains
// in-flight bits from the old backend before switching to a new one.
module shift_regs_ctrl #(
  parameter int DEPTH = 64
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [1:0]          cfg_sel,
  input  logic                cfg_load,
  shift_regs_ctrl_if.slave    bus,
  output logic                enable_shift_flops,
  output logic                enable_shift_ram,
  output logic                enable_shift_bram,
  output logic                shift_flops_din,
  output logic                shift_ram_din,
  output logic                shift_bram_din,
  input  logic                shift_flops_dout,
  input  logic                shift_ram_dout,
  input  logic                shift_bram_dout,
  output logic [1:0]          cur_sel,
  output logic                busy
);

  localparam int CW = $clog2(DEPTH + 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_RUN    = 2'd1;
  localparam logic [1:0] S_DRAIN  = 2'd2;
  localparam logic [1:0] S_SWITCH = 2'd3;

  localparam logic [1:0] SEL_FLOPS = 2'd0;
  localparam logic [1:0] SEL_RAM   = 2'd1;
  localparam logic [1:0] SEL_BRAM  = 2'd2;
  localparam logic [1:0] SEL_OFF   = 2'd3;

  localparam logic [CW-1:0] AGE_MAX = CW'(DEPTH);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [CW-1:0] CNT_ZERO = CW'(0);

  logic [1:0]    state_q, state_d;
  logic [1:0]    cur_sel_q, cur_sel_d;
  logic [1:0]    pend_sel_q, pend_sel_d;
  logic [1:0]    switch_sel_s;
  logic [CW-1:0] age_q, age_d;
  logic [CW-1:0] real_q, real_d;
  logic          out_valid_q, out_valid_d;
  logic          out_data_q, out_data_d;
  logic          accept_s, shift_s, din_s, dout_s, exit_s;

  // Shift decision and selection of the active backend's output
  always_comb begin
    accept_s = (state_q == S_RUN) && bus.in_valid;
    shift_s  = accept_s || (state_q == S_DRAIN);
    din_s    = accept_s && bus.in_data;
    case (cur_sel_q)
      SEL_FLOPS: dout_s = shift_flops_dout;
      SEL_RAM:   dout_s = shift_ram_dout;
      SEL_BRAM:  dout_s = shift_bram_dout;
      default:   dout_s = 1'b0;
    endcase
    // A bit is real only once the pipe has been fully refilled since selection.
    exit_s = shift_s && (age_q == AGE_MAX) && (real_q != CNT_ZERO);
  end

  assign enable_shift_flops = shift_s && (cur_sel_q == SEL_FLOPS);
  assign enable_shift_ram   = shift_s && (cur_sel_q == SEL_RAM);
  assign enable_shift_bram  = shift_s && (cur_sel_q == SEL_BRAM);
  assign shift_flops_din    = din_s && (cur_sel_q == SEL_FLOPS);
  assign shift_ram_din      = din_s && (cur_sel_q == SEL_RAM);
  assign shift_bram_din     = din_s && (cur_sel_q == SEL_BRAM);

  assign bus.in_ready  = (state_q == S_RUN);
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign cur_sel       = cur_sel_q;
  assign busy          = (state_q == S_DRAIN) || (state_q == S_SWITCH);

  // Next-state logic for the scheduler FSM and occupancy counters
  always_comb begin
    state_d      = state_q;
    cur_sel_d    = cur_sel_q;
    pend_sel_d   = pend_sel_q;
    age_d        = age_q;
    real_d       = real_q;
    out_valid_d  = exit_s;
    out_data_d   = exit_s && dout_s;
    switch_sel_s = cfg_load ? cfg_sel : pend_sel_q;

    if (shift_s && (age_q != AGE_MAX)) begin
      age_d = age_q + CNT_ONE;
    end else begin
      age_d = age_q;
    end

    case ({accept_s, exit_s})
      2'b10:   real_d = real_q + CNT_ONE;
      2'b01:   real_d = real_q - CNT_ONE;
      default: real_d = real_q;
    endcase

    case (state_q)
      S_IDLE, S_RUN: begin
        if (cfg_load && (cfg_sel != cur_sel_q)) begin
          pend_sel_d = cfg_sel;
          state_d    = (real_d != CNT_ZERO) ? S_DRAIN : S_SWITCH;
        end else begin
          state_d = state_q;
        end
      end
      S_DRAIN: begin
        if (cfg_load) begin
          pend_sel_d = cfg_sel;
        end else begin
          pend_sel_d = pend_sel_q;
        end
        if (real_d == CNT_ZERO) begin
          state_d = S_SWITCH;
        end else begin
          state_d = S_DRAIN;
        end
      end
      S_SWITCH: begin
        pend_sel_d = switch_sel_s;
        cur_sel_d  = switch_sel_s;
        age_d      = CNT_ZERO;
        real_d     = CNT_ZERO;
        state_d    = (switch_sel_s == SEL_OFF) ? S_IDLE : S_RUN;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and registered consumer outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      cur_sel_q   <= SEL_OFF;
      pend_sel_q  <= SEL_OFF;
      age_q       <= CNT_ZERO;
      real_q      <= CNT_ZERO;
      out_valid_q <= 1'b0;
      out_data_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cur_sel_q   <= cur_sel_d;
      pend_sel_q  <= pend_sel_d;
      age_q       <= age_d;
      real_q      <= real_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

endmodule

// File: tb/tb_shift_regs_ctrl.sv
// Directed bench for shift_regs_ctrl with behavioural models of the three
// shift-register backends (DEPTH = 16).
module tb_shift_regs_ctrl;

  localparam int DEPTH = 16;

  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic [1:0] cfg_sel = 2'd0;
  logic       cfg_load = 1'b0;
  logic       en_f, en_r, en_b, din_f, din_r, din_b;
  logic [1:0] cur_sel;
  logic       busy;
  logic [DEPTH-1:0] sr_f = '1;
  logic [DEPTH-1:0] sr_r = '1;
  logic [DEPTH-1:0] sr_b = '1;

  shift_regs_ctrl_if bus ();

  shift_regs_ctrl #(.DEPTH(DEPTH)) dut (
    .clk                (clk),
    .reset_n            (reset_n),
    .cfg_sel            (cfg_sel),
    .cfg_load           (cfg_load),
    .bus                (bus),
    .enable_shift_flops (en_f),
    .enable_shift_ram   (en_r),
    .enable_shift_bram  (en_b),
    .shift_flops_din    (din_f),
    .shift_ram_din      (din_r),
    .shift_bram_din     (din_b),
    .shift_flops_dout   (sr_f[DEPTH-1]),
    .shift_ram_dout     (sr_r[DEPTH-1]),
    .shift_bram_dout    (sr_b[DEPTH-1]),
    .cur_sel            (cur_sel),
    .busy               (busy)
  );

  always #5 clk = ~clk;

  // Backend models: dout is the bit leaving at the next enabled edge
  always @(posedge clk) begin
    if (en_f) sr_f <= {sr_f[DEPTH-2:0], din_f};
    if (en_r) sr_r <= {sr_r[DEPTH-2:0], din_r};
    if (en_b) sr_b <= {sr_b[DEPTH-2:0], din_b};
  end

  int   n_chk = 0;
  int   n_fail = 0;
  int   n_acc = 0;
  int   n_busy = 0;
  bit   seen_rb = 1'b0;
  bit   q[$];
  int   qa[$];
  logic [19:0] pat = 20'hB4EC5;

  task automatic check_val(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    bit acc;
    #1;
    acc = bus.in_valid && bus.in_ready;
    if (en_r || en_b) seen_rb = 1'b1;
    @(posedge clk);
    #1;
    if (acc) n_acc++;
    if (bus.out_valid) begin
      q.push_back(bus.out_data);
      qa.push_back(n_acc);
    end
    if (busy) n_busy++;
  endtask

  task automatic clear();
    q.delete();
    qa.delete();
    n_acc   = 0;
    n_busy  = 0;
    seen_rb = 1'b0;
  endtask

  task automatic check_reset(input string tag);
    check_val({tag, "_out"},   {bus.out_valid, bus.out_data, bus.in_ready, busy}, 0);
    check_val({tag, "_sel"},   cur_sel, 3);
    check_val({tag, "_en"},    {en_f, en_r, en_b, din_f, din_r, din_b}, 0);
  endtask

  task automatic do_reset(input string tag);
    bus.in_valid = 1'b0;
    bus.in_data  = 1'b0;
    cfg_load     = 1'b0;
    reset_n      = 1'b0;
    #1;
    check_reset(tag);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    clear();
  endtask

  task automatic cfg(input logic [1:0] sel);
    cfg_sel  = sel;
    cfg_load = 1'b1;
    tick();
    cfg_load = 1'b0;
  endtask

  task automatic feed(input int n, input bit stall);
    int idx = 0;
    int cyc = 0;
    while (idx < n) begin
      if (stall && (cyc % 3 == 2)) begin
        bus.in_valid = 1'b0;
      end else begin
        bus.in_valid = 1'b1;
        bus.in_data  = pat[idx];
        idx++;
      end
      tick();
      cyc++;
    end
    bus.in_valid = 1'b0;
    bus.in_data  = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int k = 0;
    while (busy && k < 100) begin
      tick();
      k++;
    end
    check_val({tag, "_timeout"}, busy, 0);
  endtask

  task automatic check_out(input string tag, input int first, input int count);
    check_val({tag, "_count"}, q.size(), count);
    for (int i = 0; i < count && i < q.size(); i++) begin
      check_val($sformatf("%s_bit%0d", tag, first + i), q[i], pat[first - 1 + i]);
    end
  endtask

  initial begin
    #1;
    // Steady stream on the flop backend
    do_reset("rst0");
    cfg(2'd0);
    tick();
    check_val("run_ready", bus.in_ready, 1);
    check_val("run_sel", cur_sel, 0);
    clear();
    feed(20, 1'b0);
    repeat (5) tick();
    check_out("steady", 1, 4);
    if (qa.size() > 0) check_val("steady_first_acc", qa[0], DEPTH + 1);
    check_val("steady_other_en", seen_rb, 0);

    // Same stream with a stall every third cycle
    do_reset("rst1");
    cfg(2'd0);
    tick();
    clear();
    feed(20, 1'b1);
    repeat (5) tick();
    check_out("stall", 1, 4);
    if (qa.size() > 0) check_val("stall_first_acc", qa[0], DEPTH + 1);

    // Full pipe on SRL, then move to BRAM
    do_reset("rst2");
    cfg(2'd1);
    tick();
    clear();
    feed(20, 1'b0);
    check_val("fill_pulses", q.size(), 4);
    q.delete();
    n_busy = 0;
    cfg(2'd2);
    wait_idle("drain_full");
    check_val("drain_full_busy", n_busy, DEPTH + 1);
    check_out("drain_full", 5, 16);
    check_val("drain_full_sel", cur_sel, 2);
    check_val("drain_full_ready", bus.in_ready, 1);

    // Partly filled pipe: stale flop contents must never be reported
    do_reset("rst3");
    cfg(2'd0);
    tick();
    clear();
    feed(5, 1'b0);
    check_val("part_no_early", q.size(), 0);
    n_busy = 0;
    cfg(2'd2);
    wait_idle("drain_part");
    check_val("drain_part_busy", n_busy, DEPTH + 1);
    check_out("drain_part", 1, 5);

    // Switch to off, then a load of the already-active select
    do_reset("rst4");
    cfg(2'd1);
    tick();
    check_val("sel1", cur_sel, 1);
    n_busy = 0;
    cfg(2'd3);
    wait_idle("off");
    check_val("off_busy", n_busy, 1);
    check_val("off_sel", cur_sel, 3);
    bus.in_valid = 1'b1;
    #1;
    check_val("off_ready", bus.in_ready, 0);
    check_val("off_en", {en_f, en_r, en_b, din_f, din_r, din_b}, 0);
    bus.in_valid = 1'b0;
    cfg(2'd2);
    tick();
    n_busy = 0;
    cfg(2'd2);
    tick();
    tick();
    check_val("same_busy", n_busy, 0);
    check_val("same_sel", cur_sel, 2);
    check_val("same_ready", bus.in_ready, 1);

    // Asynchronous reset in the middle of a drain
    do_reset("rst5");
    cfg(2'd0);
    tick();
    clear();
    feed(20, 1'b0);
    cfg(2'd1);
    tick();
    tick();
    check_val("mid_drain_busy", busy, 1);
    reset_n = 1'b0;
    #1;
    check_reset("rst_mid");
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    cfg(2'd0);
    tick();
    clear();
    feed(20, 1'b0);
    repeat (3) tick();
    check_out("after_rst", 1, 4);
    if (qa.size() > 0) check_val("after_rst_first_acc", qa[0], DEPTH + 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
